// File: rtl/chunked_addsub_if.sv
// Handshake and data bundle for chunked_addsub: operand side (in_*) and result side (out_*).
interface chunked_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/chunked_addsub.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock, with the ripple carry
// held in a register between chunks and valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1, last result held on sum/c_out/ovf
// CALC  | one chunk added per clock, lowest chunk first
// DONE  | result valid, held until out_ready
module chunked_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic             clk,
  input logic             rst_n,
  chunked_addsub_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic             c_out_q;
  logic             ovf_q;
  logic [IDXW-1:0]  idx;
  logic [CHUNK:0]   chunk_res;
  logic             last_chunk;

  assign last_chunk = (idx == LAST_IDX);

  // Current chunk plus carry; sum_next is the full result word once this chunk lands.
  always_comb begin
    chunk_res = {1'b0, op_a[idx*CHUNK +: CHUNK]} + {1'b0, op_b[idx*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry};
    sum_next = sum_q;
    sum_next[idx*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = CALC;
      end
      CALC: begin
        if (last_chunk) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Subtraction is a + ~b + ~borrow, so the operand and carry are inverted at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_a  <= bus.a;
            op_b  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub ? ~bus.c_in : bus.c_in;
            idx   <= '0;
          end
        end
        CALC: begin
          sum_q <= sum_next;
          carry <= chunk_res[CHUNK];
          idx   <= idx + 1'b1;
          if (last_chunk) begin
            c_out_q <= chunk_res[CHUNK];
            ovf_q   <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_next[WIDTH-1] != op_a[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: vector table through a scoreboard queue, plus
// backpressure and mid-operation reset sequences.
module tb_chunked_addsub;
  localparam int W = 16;
  localparam int NCH = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];
  vec_t vecs[13];

  chunked_addsub_if #(.WIDTH(W)) bus ();

  chunked_addsub #(.WIDTH(W), .CHUNK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: plain add, or subtract with c_in acting as borrow-in.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic tc, input logic ts);
    logic [W:0] full;
    exp_t e;
    if (!ts) begin
      full = {1'b0, ta} + {1'b0, tb_} + (W+1)'(tc);
      e.co = full[W];
      e.ov = (ta[W-1] == tb_[W-1]) && (full[W-1] != ta[W-1]);
    end else begin
      full = {1'b0, ta} - {1'b0, tb_} - (W+1)'(tc);
      e.co = ~full[W];
      e.ov = (ta[W-1] != tb_[W-1]) && (full[W-1] != ta[W-1]);
    end
    e.s = full[W-1:0];
    return e;
  endfunction

  // Returns just after the accepting edge T0.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                      input logic ts, input exp_t e);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_send", bus.in_ready, 1);
    bus.a = ta;
    bus.b = tb_;
    bus.c_in = tc;
    bus.sub = ts;
    bus.in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.c_in = 1'($urandom);
    bus.sub = 1'($urandom);
  endtask

  task automatic wait_done(input int exp_lat);
    int n;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, exp_lat);
  endtask

  task automatic check_and_consume();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: result seen with empty queue");
      return;
    end
    e = exp_q.pop_front();
    chk("sum", bus.sum, e.s);
    chk("c_out", bus.c_out, e.co);
    chk("ovf", bus.ovf, e.ov);
    chk("in_ready_in_done", bus.in_ready, 0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("out_valid_drop", bus.out_valid, 0);
    chk("in_ready_back", bus.in_ready, 1);
    chk("sum_kept_idle", bus.sum, e.s);
  endtask

  initial begin
    exp_t e;
    logic ok;
    logic saw_valid;
    n_tests = 0;
    n_fail = 0;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0005, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[6] = '{16'h0FF0, 16'h00F0, 1'b1, 1'b0, 16'h10E1, 1'b0, 1'b0};
    for (int i = 7; i < 13; i++) begin
      vecs[i].a = W'($urandom);
      vecs[i].b = W'($urandom);
      vecs[i].c_in = 1'($urandom);
      vecs[i].sub = 1'($urandom);
      e = model(vecs[i].a, vecs[i].b, vecs[i].c_in, vecs[i].sub);
      vecs[i].s = e.s;
      vecs[i].co = e.co;
      vecs[i].ov = e.ov;
    end

    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom);
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.c_in = 1'($urandom);
      bus.sub = 1'($urandom);
      bus.out_ready = 1'($urandom);
    end
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_c_out", bus.c_out, 0);
    chk("rst_ovf", bus.ovf, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      e.s = vecs[i].s;
      e.co = vecs[i].co;
      e.ov = vecs[i].ov;
      send(vecs[i].a, vecs[i].b, vecs[i].c_in, vecs[i].sub, e);
      wait_done(NCH);
      check_and_consume();
    end

    // Backpressure: result must hold while inputs churn, then the next op issues right away.
    e = model(16'h9ABC, 16'h1357, 1'b1, 1'b0);
    send(16'h9ABC, 16'h1357, 1'b1, 1'b0, e);
    wait_done(NCH);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = ~bus.in_valid;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.sub = 1'($urandom);
      bus.c_in = 1'($urandom);
      @(posedge clk);
      #1;
      if (bus.sum !== e.s || bus.c_out !== e.co || bus.ovf !== e.ov ||
          bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) ok = 1'b0;
    end
    chk("backpressure_hold", ok, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_and_consume();
    bus.a = 16'h4000;
    bus.b = 16'h4000;
    bus.c_in = 1'b0;
    bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    exp_q.push_back(model(16'h4000, 16'h4000, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("reissue_accepted", bus.in_ready, 0);
    wait_done(NCH);
    check_and_consume();

    // Reset in the second CALC cycle: no output pulse, everything back to zero.
    e = model(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h1111, 16'h2222, 1'b0, 1'b0, e);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_sum", bus.sum, 0);
    chk("midrst_c_out", bus.c_out, 0);
    chk("midrst_ovf", bus.ovf, 0);
    exp_q.delete();
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (bus.out_valid) saw_valid = 1'b1;
    end
    chk("midrst_no_pulse", saw_valid, 0);
    chk("midrst_sum_after", bus.sum, 0);
    e.s = 16'h0100;
    e.co = 1'b0;
    e.ov = 1'b0;
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, e);
    wait_done(NCH);
    check_and_consume();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
